// File: rtl/line_encoder_serial.sv
// line_encoder_serial: captures a multi-hot line vector and streams each set index, MSB first, over valid/ready.
// Optional ENC_COUNT_EN adds o_count, the number of indices still to be emitted.
module line_encoder_serial #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_enable,
   input  logic         i_load,
   input  logic [N-1:0] i_d,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_code,
   output logic         o_last,
   output logic         o_busy,
   output logic         o_none
`ifdef ENC_COUNT_EN
   ,
   output logic [W:0]   o_count
`endif
);
   typedef enum logic {S_IDLE, S_EMIT} state_t;
   state_t       r_state, w_state_nxt;
   logic [N-1:0] r_pending, w_pending_nxt;
   logic [W-1:0] r_code, w_code_nxt;
   logic         r_last, w_last_nxt;
   logic         r_valid, w_valid_nxt;
   logic         r_none, w_none_nxt;
   logic         w_capture, w_take, w_accept;

   function automatic logic [W-1:0] f_msb(input logic [N-1:0] p);
      f_msb = '0;
      for (int i = 0; i < N; i++)
         if (p[i]) f_msb = W'(i);
   endfunction

   assign w_capture = i_enable & i_load & (r_state == S_IDLE);
   assign w_take    = w_capture & (i_d != '0);
   assign w_accept  = i_enable & i_ready & (r_state == S_EMIT);

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;

   always_comb begin
      w_state_nxt = r_state;
      if (w_take) w_state_nxt = S_EMIT;
      else if (w_accept && r_last) w_state_nxt = S_IDLE;
   end

   // Outputs are precomputed from the next pending vector so they can be registered.
   always_comb begin
      w_pending_nxt = w_take ? i_d : w_accept ? (r_pending & ~(N'(1) << r_code)) : r_pending;
      w_code_nxt    = f_msb(w_pending_nxt);
      w_last_nxt    = (w_pending_nxt != '0) && ((w_pending_nxt & (w_pending_nxt - N'(1))) == '0);
      w_valid_nxt   = w_state_nxt == S_EMIT;
      w_none_nxt    = w_capture & (i_d == '0);
   end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_pending <= '0;
         r_code    <= '0;
         r_last    <= 1'b0;
         r_valid   <= 1'b0;
         r_none    <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         r_code    <= w_code_nxt;
         r_last    <= w_last_nxt;
         r_valid   <= w_valid_nxt;
         r_none    <= w_none_nxt;
      end

   assign o_valid = r_valid;
   assign o_busy  = r_valid;
   assign o_code  = r_code;
   assign o_last  = r_last;
   assign o_none  = r_none;

`ifdef ENC_COUNT_EN
   logic [W:0] r_count;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst)         r_count <= '0;
      else if (w_take)   r_count <= (W+1)'($countones(i_d));
      else if (w_accept) r_count <= r_count - 1'b1;
   assign o_count = r_count;
`endif
endmodule

// File: tb/tb_line_encoder_serial.sv
// tb_line_encoder_serial: directed checks of capture, MSB-first emission, stall, freeze and reset.
module tb_line_encoder_serial;
   logic       clk = 1'b0;
   logic       rst, en, load, ready;
   logic [7:0] d;
   logic       valid, last, busy, none;
   logic [2:0] code;
   int         total = 0;
   int         bad = 0;
`ifdef ENC_COUNT_EN
   logic [3:0] count;
   logic [7:0] dec;
`endif

   line_encoder_serial #(.N(8), .W(3)) dut (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_load(load), .i_d(d), .i_ready(ready),
      .o_valid(valid), .o_code(code), .o_last(last), .o_busy(busy), .o_none(none)
`ifdef ENC_COUNT_EN
      , .o_count(count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [2:0] c, input logic l);
      chk({tag, ".valid"}, 32'(valid), 32'(v));
      chk({tag, ".busy"},  32'(busy),  32'(v));
      chk({tag, ".code"},  32'(code),  32'(c));
      chk({tag, ".last"},  32'(last),  32'(l));
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; load = 1'b0; d = 8'h00; ready = 1'b0;
      tick(); tick();
      chk_out("reset", 1'b0, 3'd0, 1'b0);
      chk("reset.none", 32'(none), 32'd0);
`ifdef ENC_COUNT_EN
      chk("reset.count", 32'(count), 32'd0);
`endif
      rst = 1'b0;
      // async reset mid-EMIT
      load = 1'b1; d = 8'b10100101;
      tick();
      chk_out("rst_pre", 1'b1, 3'd7, 1'b0);
      load = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk_out("rst_async", 1'b0, 3'd0, 1'b0);
      tick();
      rst = 1'b0; load = 1'b1; d = 8'b00000010;
      tick();
      chk_out("rst_recap", 1'b1, 3'd1, 1'b1);
      load = 1'b0; ready = 1'b1;
      tick();
      chk_out("rst_done", 1'b0, 3'd0, 1'b0);
      // streaming with ready held high
      load = 1'b1; d = 8'b10100101;
      tick();
      chk_out("seq0", 1'b1, 3'd7, 1'b0);
      load = 1'b0;
      tick(); chk_out("seq1", 1'b1, 3'd5, 1'b0);
      tick(); chk_out("seq2", 1'b1, 3'd2, 1'b0);
      tick(); chk_out("seq3", 1'b1, 3'd0, 1'b1);
      // load on the final accept edge is ignored, then re-accepted one cycle later
      load = 1'b1; d = 8'b00000011;
      tick(); chk_out("gap", 1'b0, 3'd0, 1'b0);
      chk("gap.none", 32'(none), 32'd0);
      tick(); chk_out("b2b0", 1'b1, 3'd1, 1'b0);
      load = 1'b0;
      tick(); chk_out("b2b1", 1'b1, 3'd0, 1'b1);
      tick(); chk_out("b2b_idle", 1'b0, 3'd0, 1'b0);
      // stall with ready low; load during EMIT must not alter pending
      ready = 1'b0; load = 1'b1; d = 8'b01000001;
      tick(); chk_out("stall0", 1'b1, 3'd6, 1'b0);
      d = 8'b11111111;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("stall", 1'b1, 3'd6, 1'b0);
      end
      load = 1'b0; ready = 1'b1;
      tick(); chk_out("stall_rel", 1'b1, 3'd0, 1'b1);
      tick(); chk_out("stall_idle", 1'b0, 3'd0, 1'b0);
      // empty load
      load = 1'b1; d = 8'h00;
      tick(); chk_out("none_hit", 1'b0, 3'd0, 1'b0);
      chk("none.pulse", 32'(none), 32'd1);
      load = 1'b0;
      tick(); chk("none.clear", 32'(none), 32'd0);
      // enable low in IDLE: no capture, no None
      en = 1'b0; load = 1'b1; d = 8'h00;
      tick(); chk("en_idle.none", 32'(none), 32'd0);
      d = 8'h10;
      tick(); chk_out("en_idle", 1'b0, 3'd0, 1'b0);
      // freeze during EMIT
      en = 1'b1; d = 8'b10010010;
      tick(); chk_out("frz0", 1'b1, 3'd7, 1'b0);
      load = 1'b0; en = 1'b0;
      tick(); chk_out("frz1", 1'b1, 3'd7, 1'b0);
      tick(); chk_out("frz2", 1'b1, 3'd7, 1'b0);
      en = 1'b1;
      tick(); chk_out("frz3", 1'b1, 3'd4, 1'b0);
      tick(); chk_out("frz4", 1'b1, 3'd1, 1'b1);
      tick(); chk_out("frz_idle", 1'b0, 3'd0, 1'b0);
`ifdef ENC_COUNT_EN
      // count alongside code, decoded code names the cleared bit
      load = 1'b1; d = 8'b11110000;
      tick();
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("cnt.code", 32'(code), 32'(7 - i));
         chk("cnt.count", 32'(count), 32'(4 - i));
         dec = 8'd1 << code;
         chk("cnt.dec", 32'(dec), 32'(8'h80 >> i));
         tick();
      end
      chk("cnt.zero", 32'(count), 32'd0);
      chk("cnt.valid", 32'(valid), 32'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/line_encoder_serial.md
Name: line_encoder_serial

Overview:
- Sequential inverse of the team's 3-to-8 line decode function.
- Captures a multi-hot line vector and emits the binary index of every asserted line, one per accepted transfer, highest index first.
- Output side uses a valid/ready handshake, so a downstream line decoder or consumer can stall it.
- Sits between request-line sources (interrupt or select lines) and index-driven logic.

Parameters:
- N, 8, number of input lines (N >= 2).
- W, 3, index width; must equal ceil(log2(N)).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  global enable; low freezes all state.
- Load  input  1  capture request for D (IDLE only).
- D  input  N  line vector; bit i set means line i asserted.
- Ready  input  1  downstream accepts Code this cycle.
- Valid  output  1  Code is valid.
- Code  output  W  index of the current highest set pending line.
- Last  output  1  current Code is the final pending line.
- Busy  output  1  block is not IDLE.
- None  output  1  one-cycle pulse: Load seen with D == 0.
- Count  output  W+1  popcount of the captured vector (ENC_COUNT_EN only).

Behaviour:
- Reset (async, any time, including mid-EMIT):
  - state=IDLE, pending=0.
  - Valid=0, Code=0, Last=0, Busy=0, None=0, Count=0.
  - Takes effect immediately. The first capture is possible on the first edge after Reset deasserts.
- All outputs are registered. No combinational path from inputs to outputs.
- State IDLE:
  - Valid=0, Busy=0.
  - On an edge with Enable=1, Load=1, D!=0: pending<=D, state<=EMIT.
  - Valid, Busy, Code and Last become visible after that same edge (1-cycle latency).
  - On an edge with Enable=1, Load=1, D==0: None<=1 for one cycle, state stays IDLE.
- State EMIT:
  - Valid=1, Busy=1.
  - Code = highest i with pending[i]=1 (MSB priority).
  - Last=1 iff popcount(pending)==1.
  - Accept = Valid & Ready & Enable at the edge. On accept, clear pending[Code] and update Code/Last to the next highest bit.
  - If the accepted transfer had Last=1, state<=IDLE. Valid, Busy and Last are 0 after that edge.
  - Ready=0: Code, Last and Valid hold stable; no bits are cleared.
  - Load is ignored in EMIT and does not alter pending.
- Enable=0 (any state):
  - No capture, no accept, no state change.
  - Outputs hold their last values; None is forced 0.
- Throughput: one index per cycle while Ready=1.
  - A vector with k set bits completes in k accepts.
  - Load is re-accepted on the edge after the Last accept. Back-to-back vectors have a 1-cycle Valid gap.
- Simultaneous Load and final accept on the same edge: Load is ignored (state was EMIT at that edge).
- Index arithmetic: Code is W bits. Bit N-1 encodes as N-1. No wrap.

Optional Feature:
- Macro: ENC_COUNT_EN.
- Defined:
  - Count port exists.
  - On capture, Count <= popcount(D).
  - On each accept, Count decrements by 1; it reads 0 in IDLE after completion.
  - Count resets to 0 and holds while Enable=0.
- Undefined: Count port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset=1 mid-EMIT with D=8'b10100101 loaded -> immediately Valid=0, Busy=0, Code=0. After release, Load D=8'b00000010 -> Code=1, Last=1 next cycle.
- Ready held 1, Load D=8'b10100101 -> Code sequence 7,5,2,0 on consecutive cycles. Last=1 only with Code=0; Busy=0 the cycle after.
- Load D=8'b01000001, Ready=0 for 3 cycles -> Code=6, Valid=1 stable for all 3. Ready=1 -> Code=0, Last=1, then IDLE.
- Load D=8'b00000000 -> None=1 for exactly one cycle, Valid=0, Busy=0.
- Enable=0 for 2 cycles during EMIT with Ready=1 -> Code frozen at current index, no bits cleared. Enable=1 -> sequence resumes unchanged.
- ENC_COUNT_EN defined, Load D=8'b11110000 -> Count 4,3,2,1 alongside Code 7,6,5,4, then Count=0. Feeding Code into a 3-to-8 decoder (Enable=1) yields one-hot F equal to each cleared bit.
